// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM encoding, idle row pattern and hex-key to
// (column,row) mapping used by the emulator and the keypad encoder bench.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ALIGN   = 2'd3
  } state_t;

  localparam logic [3:0] NO_KEY = 4'b1111;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  // Keys 1..F occupy positions 0..14 in scan order; key 0 sits at the last slot.
  function automatic key_pos_t key_to_pos(input logic [3:0] code);
    logic [3:0] idx;
    key_pos_t   pos;
    idx     = code - 4'd1;
    pos.col = idx[1:0];
    pos.row = idx[3:2];
    return pos;
  endfunction

  function automatic logic [3:0] row_mask(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Request, scan and status signals between a keypad scanner/host and the emulator.
interface keypad_emulator_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [1:0] counter;
  logic [3:0] keyboard;
  logic       busy;
  logic       done;

  modport master (
    output key_code, key_valid, counter,
    input  key_ready, keyboard, busy, done
  );

  modport slave (
    input  key_code, key_valid, counter,
    output key_ready, keyboard, busy, done
  );
endinterface

// File: rtl/keypad_scan_wrap.sv
// Detects the end of a full column scan: previous counter 3 followed by counter 0.
module keypad_scan_wrap (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] counter,
  output logic       wrap
);
  logic [1:0] counter_prev;

  always_ff @(posedge clock) begin
    if (reset) counter_prev <= 2'b00;
    else       counter_prev <= counter;
  end

  assign wrap = (counter_prev == 2'b11) && (counter == 2'b00);
endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: holds one hex key pressed for PRESS_SCANS scans, then released
// for RELEASE_SCANS scans. Define KEYPAD_EMU_ALIGN_EN to start presses on a scan boundary.
//
// state      | meaning
// IDLE       | waiting for a request, key_ready high
// ALIGN      | request taken, waiting for the first scan wrap (align build only)
// PRESS      | row driven low while counter matches the latched column
// RELEASE    | all rows released, counting release scans
import keypad_pkg::*;

module keypad_emulator #(
  parameter int PRESS_SCANS   = 4,
  parameter int RELEASE_SCANS = 2
) (
  input  logic               clock,
  input  logic               reset,
  keypad_emulator_if.slave   kif
);
  localparam logic [3:0] PRESS_LAST   = 4'(PRESS_SCANS - 1);
  localparam logic [3:0] RELEASE_LAST = 4'(RELEASE_SCANS - 1);

  state_t     state;
  logic [3:0] scan_cnt;
  logic [3:0] code_q;
  logic [3:0] keyboard_q;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic       wrap;
  key_pos_t   pos_q;

  assign pos_q = key_to_pos(code_q);

`ifndef KEYPAD_EMU_ALIGN_EN
  key_pos_t pos_in;
  assign pos_in = key_to_pos(kif.key_code);
`endif

  keypad_scan_wrap u_scan_wrap (
    .clock   (clock),
    .reset   (reset),
    .counter (kif.counter),
    .wrap    (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      scan_cnt   <= 4'd0;
      code_q     <= 4'h0;
      keyboard_q <= NO_KEY;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      keyboard_q <= NO_KEY;
      case (state)
        ST_IDLE: begin
          if (kif.key_valid) begin
            code_q   <= kif.key_code;
            scan_cnt <= 4'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef KEYPAD_EMU_ALIGN_EN
            state    <= ST_ALIGN;
`else
            state    <= ST_PRESS;
            if (kif.counter == pos_in.col) keyboard_q <= row_mask(pos_in.row);
`endif
          end
        end
        ST_ALIGN: begin
          // The aligning wrap itself does not count toward the press length.
          if (wrap) begin
            state    <= ST_PRESS;
            scan_cnt <= 4'd0;
            if (kif.counter == pos_q.col) keyboard_q <= row_mask(pos_q.row);
          end
        end
        ST_PRESS: begin
          if (wrap && scan_cnt == PRESS_LAST) begin
            state    <= ST_RELEASE;
            scan_cnt <= 4'd0;
          end else begin
            if (wrap) scan_cnt <= scan_cnt + 4'd1;
            if (kif.counter == pos_q.col) keyboard_q <= row_mask(pos_q.row);
          end
        end
        ST_RELEASE: begin
          if (wrap) begin
            if (scan_cnt == RELEASE_LAST) begin
              state    <= ST_IDLE;
              scan_cnt <= 4'd0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              scan_cnt <= scan_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign kif.keyboard  = keyboard_q;
  assign kif.key_ready = ready_q;
  assign kif.busy      = busy_q;
  assign kif.done      = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: per-edge expectations derived from the
// planned counter stream, plus a done scoreboard with a behavioural key encoder.
module tb_keypad_emulator;
  localparam int P    = 4;
  localparam int R    = 2;
  localparam int MAXE = 6000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  keypad_emulator_if kif();

  keypad_emulator #(.PRESS_SCANS(P), .RELEASE_SCANS(R)) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  typedef struct {
    logic [3:0] code;
    int         done_edge;
  } txn_t;

  txn_t       sb[$];
  logic [1:0] cnt[MAXE];
  logic [3:0] exp_kb[MAXE];
  bit         exp_busy[MAXE];
  bit         exp_done[MAXE];
  int         ecount = 0;
  int         errors = 0;
  int         checks = 0;
  int         seen_code = -1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, ecount, act, want);
    end
  endfunction

  // Behavioural scanner-side encoder: active-low row plus scanned column -> hex key.
  function automatic int decode(input logic [3:0] kb, input logic [1:0] col);
    int row;
    case (kb)
      4'b1110: row = 0;
      4'b1101: row = 1;
      4'b1011: row = 2;
      4'b0111: row = 3;
      default: return -1;
    endcase
    return (row * 4 + int'(col) + 1) % 16;
  endfunction

  function automatic void gen_from(input int s);
    for (int e = s; e < MAXE; e++)
      cnt[e] = ($urandom_range(0, 3) == 0) ? cnt[e-1] : cnt[e-1] + 2'd1;
  endfunction

  function automatic int next_wrap(input int x);
    for (int e = x + 1; e < MAXE; e++)
      if (cnt[e-1] == 2'd3 && cnt[e] == 2'd0) return e;
    return -1;
  endfunction

  // Expected behaviour of one request accepted at edge a, from the wrap positions.
  function automatic int plan(input int a, input logic [3:0] code);
    int idx, col, row, start, p_end, r_end;
    idx   = (int'(code) + 15) % 16;
    col   = idx % 4;
    row   = idx / 4;
    start = a;
`ifdef KEYPAD_EMU_ALIGN_EN
    start = next_wrap(a);
`endif
    p_end = start;
    for (int i = 0; i < P; i++) if (p_end >= 0) p_end = next_wrap(p_end);
    r_end = p_end;
    for (int i = 0; i < R; i++) if (r_end >= 0) r_end = next_wrap(r_end);
    if (r_end < 0) return -1;
    for (int e = a; e <= r_end; e++) begin
      exp_busy[e] = (e < r_end);
      exp_done[e] = (e == r_end);
      exp_kb[e]   = (e >= start && e < p_end && int'(cnt[e]) == col) ? ~(4'b0001 << row) : 4'hF;
    end
    sb.push_back('{code, r_end});
    return r_end;
  endfunction

  task automatic tick(input logic v, input logic [3:0] c);
    kif.key_valid = v;
    kif.key_code  = c;
    kif.counter   = cnt[ecount + 1];
    @(posedge clock);
    ecount++;
    #1;
  endtask

  task automatic run_episode(input logic [3:0] code);
    int a, r_end;
    a     = ecount + 1;
    r_end = plan(a, code);
    if (r_end < 0) begin
      $display("FAIL plan_budget edge=%0d got=no_wrap want=wrap", ecount);
      $fatal(1, "counter plan exhausted");
    end
    tick(1'b1, code);
    while (ecount < r_end) tick(1'(($urandom_range(0, 1))), 4'($urandom_range(0, 15)));
  endtask

  always @(negedge clock) begin
    if (ecount > 0) begin
      chk("keyboard", 32'(kif.keyboard), 32'(exp_kb[ecount]));
      chk("busy", 32'(kif.busy), 32'(exp_busy[ecount]));
      chk("key_ready", 32'(kif.key_ready), 32'(!exp_busy[ecount]));
      chk("done", 32'(kif.done), 32'(exp_done[ecount]));
      if (kif.keyboard !== 4'hF) seen_code = decode(kif.keyboard, cnt[ecount]);
      if (kif.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_without_request", 32'd1, 32'd0);
        end else begin
          txn_t t;
          t = sb.pop_front();
          chk("done_edge", 32'(ecount), 32'(t.done_edge));
          chk("loopback_code", 32'(seen_code), 32'(t.code));
          seen_code = -1;
        end
      end
    end
  end

  initial begin
    int a, r_end, r;
    for (int e = 0; e < MAXE; e++) begin
      cnt[e] = 2'd0; exp_kb[e] = 4'hF; exp_busy[e] = 1'b0; exp_done[e] = 1'b0;
    end
    reset = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    kif.counter   = 2'd0;
    gen_from(4);
    repeat (3) tick(1'b0, 4'h0);
    reset = 1'b0;

    // All 16 codes first, then random codes; zero gap exercises accept right after done.
    for (int i = 0; i < 36; i++) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, 4'($urandom_range(0, 15)));
      run_episode(i < 16 ? 4'(i) : 4'($urandom_range(0, 15)));
    end

    // Counter frozen at 2 right after acceptance: sequence must stall, busy held.
    a = ecount + 1;
    for (int e = a + 1; e <= a + 60; e++) cnt[e] = 2'd2;
    gen_from(a + 61);
    run_episode(4'h6);

    // Reset mid-sequence: abort, no done, idle outputs from the reset edge on.
    tick(1'b0, 4'h0);
    a     = ecount + 1;
    r_end = plan(a, 4'h0);
    tick(1'b1, 4'h0);
    repeat (6) tick(1'b1, 4'($urandom_range(0, 15)));
    r = ecount + 1;
    cnt[r] = 2'd0;
    gen_from(r + 1);
    for (int e = r; e <= r_end && e < MAXE; e++) begin
      exp_kb[e] = 4'hF; exp_busy[e] = 1'b0; exp_done[e] = 1'b0;
    end
    void'(sb.pop_back());
    reset = 1'b1;
    tick(1'b0, 4'h0);
    reset = 1'b0;
    repeat (3) tick(1'b0, 4'h0);
    run_episode(4'h4);
    repeat (3) tick(1'b0, 4'h0);

    chk("pending_requests", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
